alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Multi-cycle issue controller that drives the team's 8-bit combinational ALU from the other side. It accepts 9-bit two-address instructions over a valid/ready handshake and reads operands from an internal 8-entry register file. It presents operand and opcode values to the ALU through registers, captures the ALU result and zero flag, and writes the result back. It sits between the fetch/host logic and the ALU, and is the only block that drives the ALU's operand and opcode inputs.

## Interface
- DATA_W, 8, datapath and register width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction present on instr
- instr  in  9  [8:6] ALU opcode, [5:3] rd (also source A), [2:0] rs (source B)
- instr_ready  out  1  controller can accept an instruction (high only in IDLE)
- rf_wr_en  in  1  host register write request
- rf_wr_addr  in  3  host write address
- rf_wr_data  in  DATA_W  host write data
- rf_rd_addr  in  3  debug read address
- rf_rd_data  out  DATA_W  combinational read of rf[rf_rd_addr]; r0 reads 0
- alu_input_a  out  DATA_W  registered operand A to ALU
- alu_input_b  out  DATA_W  registered operand B to ALU
- alu_opcode  out  3  registered opcode to ALU
- alu_out  in  DATA_W  ALU result, combinational from the outputs above
- alu_zero  in  1  ALU zero flag
- done  out  1  one-cycle pulse: instruction retired
- result_out  out  DATA_W  captured result, held until the next capture
- zero_flag  out  1  captured alu_zero, held until the next capture

## Operation
- Register file: 8 x DATA_W.
  - r0 is hardwired to 0: writes to r0 are discarded and reads of r0 return 0.
- FSM has four states: IDLE -> FETCH_OPS -> EXECUTE -> WRITEBACK -> IDLE.
- IDLE:
  - instr_ready=1.
  - Handshake: on instr_valid&&instr_ready, latch instr into the IR and go to FETCH_OPS. Otherwise stay in IDLE.
  - A host write (rf_wr_en) is performed in IDLE only.
- FETCH_OPS:
  - alu_input_a <= rf[rd], alu_input_b <= rf[rs], alu_opcode <= IR[8:6].
  - Go to EXECUTE.
- EXECUTE:
  - ALU inputs are stable.
  - result_out <= alu_out, zero_flag <= alu_zero.
  - Go to WRITEBACK.
- WRITEBACK:
  - rf[rd] <= result_out, suppressed when rd=0.
  - done=1.
  - Go to IDLE.
- All eight opcodes are treated identically, including the compare and overflow ops. The controller never interprets the opcode value.
- Host write and instruction acceptance in the same IDLE cycle: both occur. The new register value is visible to that instruction's FETCH_OPS read.
- rf_wr_en outside IDLE: ignored and dropped. It is not queued.
- alu_input_a, alu_input_b and alu_opcode hold their values from WRITEBACK through IDLE until the next FETCH_OPS.
- Reset, including mid-instruction:
  - State goes to IDLE and any in-flight instruction is aborted with no writeback and no done.
  - All registers, the register file, alu_input_a, alu_input_b, alu_opcode, result_out and zero_flag go to 0.
  - done goes to 0 and instr_ready goes to 1.

## Timing
- Accept edge = cycle 0.
  - Cycle 1 (FETCH_OPS): operands are registered at the end of the cycle.
  - Cycle 2 (EXECUTE): result is captured at the end of the cycle.
  - Cycle 3 (WRITEBACK): done is high; the register file is written at the end of the cycle.
- Latency: done is asserted 3 cycles after the accept edge. result_out and zero_flag are valid in the same cycle as done.
- Throughput: 1 instruction per 4 cycles with instr_valid held high. The next accept occurs in the cycle after WRITEBACK.
- Back-to-back dependency: the WRITEBACK write completes before the next FETCH_OPS, so no hazard exists and no forwarding is needed.
- The ALU path is combinational from registered outputs to captured inputs: one full cycle is allowed.
- Asynchronous reset takes effect on outputs immediately, without waiting for a clock edge.

## Test plan
- Add:
  - Setup: after reset, host write r1=0x05, r2=0x03.
  - Stimulus: instr {001,001,010}.
  - Required response: done 3 cycles after accept; result_out=0x08, zero_flag=0; rf_rd_data(r1)=0x08.
- Zero result:
  - Stimulus: instr {010,001,001} (r1 XOR r1).
  - Required response: result_out=0x00, zero_flag=1, r1=0x00.
- Overflow op and r0 target:
  - Setup: r1=0x7F, r2=0x01.
  - Stimulus 1: instr {111,001,010}. Required response: result_out=0x01, r1=0x01.
  - Stimulus 2: instr {001,000,010}. Required response: result_out=0x01, r0 still reads 0x00.
- Back-to-back:
  - Setup: r1=0x01, r2=0x01.
  - Stimulus: instr_valid held high with instr {001,001,010} twice.
  - Required response: accepts 4 cycles apart; the second result is 0x03, proving the first writeback is visible.
- Busy write and same-cycle write:
  - Busy write: rf_wr_en to r5=0xAA during EXECUTE -> r5 stays 0x00.
  - Same-cycle write: in an IDLE cycle, host write r2=0x10 together with accepting {001,001,010} where r1=0x01 -> result_out=0x11.
- Reset mid-op:
  - Stimulus: assert reset during EXECUTE.
  - Required response: no done pulse; all outputs 0, instr_ready=1 immediately; every register reads 0x00 afterwards.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue controller for the 8-bit combinational ALU.
// Holds an 8-entry register file (r0 reads as zero). It registers the operands
// and the opcode toward the ALU, captures the result and the zero flag, and
// writes the result back to rd.
module alu_issue_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [8:0]        instr,
   output logic              instr_ready,
   input  logic              rf_wr_en,
   input  logic [2:0]        rf_wr_addr,
   input  logic [DATA_W-1:0] rf_wr_data,
   input  logic [2:0]        rf_rd_addr,
   output logic [DATA_W-1:0] rf_rd_data,
   output logic [DATA_W-1:0] alu_input_a,
   output logic [DATA_W-1:0] alu_input_b,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   output logic              done,
   output logic [DATA_W-1:0] result_out,
   output logic              zero_flag
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_FETCH_OPS = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [8:0]        r_ir;
   logic [DATA_W-1:0] r_rf [8];
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [2:0]        r_alu_op;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic [2:0]        w_rd;
   logic [2:0]        w_rs;
   logic              w_accept;
   logic              w_host_wr;

   // r0 is architecturally zero no matter what the array holds
   function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] addr,
                                                 input logic [DATA_W-1:0] val);
      rf_read = (addr == 3'd0) ? '0 : val;
   endfunction

   assign w_rd        = r_ir[5:3];
   assign w_rs        = r_ir[2:0];
   assign w_accept    = instr_valid && (r_state == S_IDLE);
   assign w_host_wr   = rf_wr_en && (r_state == S_IDLE) && (rf_wr_addr != 3'd0);
   assign rf_rd_data  = rf_read(rf_rd_addr, r_rf[rf_rd_addr]);
   assign alu_input_a = r_alu_a;
   assign alu_input_b = r_alu_b;
   assign alu_opcode  = r_alu_op;
   assign result_out  = r_result;
   assign zero_flag   = r_zero;

   // State register; reset aborts any in-flight instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state sequencing and handshake/retire outputs
   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) w_next = S_FETCH_OPS;
         end
         S_FETCH_OPS: w_next = S_EXECUTE;
         S_EXECUTE:   w_next = S_WRITEBACK;
         S_WRITEBACK: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Instruction latch, ALU operand registers and result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir     <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         if (w_accept) r_ir <= instr;
         if (r_state == S_FETCH_OPS) begin
            r_alu_a  <= rf_read(w_rd, r_rf[w_rd]);
            r_alu_b  <= rf_read(w_rs, r_rf[w_rs]);
            r_alu_op <= r_ir[8:6];
         end
         if (r_state == S_EXECUTE) begin
            r_result <= alu_out;
            r_zero   <= alu_zero;
         end
      end
   end

   // Register file: host writes only in IDLE, result writeback only in WRITEBACK
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_rf[i] <= '0;
      end else begin
         if (w_host_wr) r_rf[rf_wr_addr] <= rf_wr_data;
         if ((r_state == S_WRITEBACK) && (w_rd != 3'd0)) r_rf[w_rd] <= r_result;
      end
   end

endmodule
